// File: rtl/fb_draw_scheduler_pkg.sv
// Shared types and constants for the frame-buffer draw scheduler.
// Optional background clear is selected with FB_DRAW_CLEAR_EN.
package fb_sched_pkg;

    localparam int COOR_WIDTH     = 12;
    localparam int NUM_REQ        = 4;
    localparam int DIM_WIDTH      = 8;
    localparam int ROM_ADDR_WIDTH = 14;

    localparam logic [2:0] CLEAR_PALETTE       = 3'd7;
    localparam logic [2:0] TRANSPARENT_PALETTE = 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BLANK,
        ST_CLEAR,
        ST_SELECT,
        ST_DRAW,
        ST_DRAIN
    } fb_state_t;

    typedef struct packed {
        logic                      en;
        logic [COOR_WIDTH-1:0]     x;
        logic [COOR_WIDTH-1:0]     y;
        logic [DIM_WIDTH-1:0]      w;
        logic [DIM_WIDTH-1:0]      h;
        logic [ROM_ADDR_WIDTH-1:0] base;
    } spr_desc_t;

    // One slot of the write pipeline: rd takes its palette from the ROM,
    // clr forces the background colour, neither means no write.
    typedef struct packed {
        logic                  rd;
        logic                  clr;
        logic [COOR_WIDTH-1:0] x;
        logic [COOR_WIDTH-1:0] y;
    } pipe_slot_t;

endpackage

// File: rtl/fb_draw_scheduler_if.sv
// Requester, sprite-ROM and frame-buffer write bus of the draw scheduler.
// master is the scheduler side, slave is the surrounding system.
interface fb_draw_scheduler_if;
    import fb_sched_pkg::*;

    logic                                     rst_screen_33m;
    logic [NUM_REQ-1:0]                       spr_en;
    logic [NUM_REQ-1:0][COOR_WIDTH-1:0]       spr_x;
    logic [NUM_REQ-1:0][COOR_WIDTH-1:0]       spr_y;
    logic [NUM_REQ-1:0][DIM_WIDTH-1:0]        spr_w;
    logic [NUM_REQ-1:0][DIM_WIDTH-1:0]        spr_h;
    logic [NUM_REQ-1:0][ROM_ADDR_WIDTH-1:0]   spr_base;
    logic                                     rom_rd;
    logic [ROM_ADDR_WIDTH-1:0]                rom_addr;
    logic [2:0]                               rom_q;
    logic [COOR_WIDTH-1:0]                    write_x;
    logic [COOR_WIDTH-1:0]                    write_y;
    logic [2:0]                               write_palette;
    logic [NUM_REQ-1:0]                       spr_done;
    logic                                     frame_busy;
    logic                                     overrun;

    modport master (
        input  rst_screen_33m, spr_en, spr_x, spr_y, spr_w, spr_h, spr_base, rom_q,
        output rom_rd, rom_addr, write_x, write_y, write_palette, spr_done,
               frame_busy, overrun
    );

    modport slave (
        output rst_screen_33m, spr_en, spr_x, spr_y, spr_w, spr_h, spr_base, rom_q,
        input  rom_rd, rom_addr, write_x, write_y, write_palette, spr_done,
               frame_busy, overrun
    );

endinterface

// File: rtl/fb_draw_scheduler_rect_walker.sv
// Row-major u/v walker over a w x h rectangle; u advances fastest.
// Used for both sprite rectangles and the full-frame clear.
module fb_rect_walker #(
    parameter int WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] w_i,
    input  logic [WIDTH-1:0] h_i,
    output logic [WIDTH-1:0] u_o,
    output logic [WIDTH-1:0] v_o,
    output logic             last_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] u_q, v_q, w_q, h_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            u_q <= '0;
            v_q <= '0;
            w_q <= '0;
            h_q <= '0;
        end else if (start_i) begin
            u_q <= '0;
            v_q <= '0;
            w_q <= w_i;
            h_q <= h_i;
        end else if (step_i) begin
            if (u_q == w_q - ONE) begin
                u_q <= '0;
                v_q <= v_q + ONE;
            end else begin
                u_q <= u_q + ONE;
            end
        end
    end

    assign u_o    = u_q;
    assign v_o    = v_q;
    assign last_o = (u_q == w_q - ONE) && (v_q == h_q - ONE);

endmodule

// File: rtl/fb_draw_scheduler.sv
// Sequences sprite (and optional background clear) writes into the off-screen
// frame buffer; define FB_DRAW_CLEAR_EN to clear the buffer every frame.
module fb_draw_scheduler
    import fb_sched_pkg::*;
#(
    parameter int ROM_LATENCY = 2,
    parameter int FRAME_W     = 1280,
    parameter int FRAME_H     = 300
) (
    input  logic                clk_33m,
    input  logic                rst_n,
    fb_draw_scheduler_if.master bus
);

    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = SEL_W + 1;
    localparam int DRN_W = $clog2(ROM_LATENCY + 1) + 1;

    fb_state_t                 state_q;
    logic                      rs_q;
    spr_desc_t                 desc_q [NUM_REQ];
    logic [IDX_W-1:0]          idx_q;
    logic [DRN_W-1:0]          drain_q;
    pipe_slot_t                pipe_q [ROM_LATENCY+1];
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q;
    logic [ROM_ADDR_WIDTH-1:0] addr_cnt_q;
    logic [NUM_REQ-1:0]        spr_done_q;
    logic                      frame_busy_q;
    logic                      overrun_q;
    logic [COOR_WIDTH-1:0]     wx_q;
    logic [COOR_WIDTH-1:0]     wy_q;
    logic [2:0]                wpal_q;

    logic                      frame_start;
    spr_desc_t                 cur_desc;
    logic                      cur_drawable;
    logic                      walk_start;
    logic                      walk_step;
    logic [COOR_WIDTH-1:0]     walk_w;
    logic [COOR_WIDTH-1:0]     walk_h;
    logic [COOR_WIDTH-1:0]     walk_u;
    logic [COOR_WIDTH-1:0]     walk_v;
    logic                      walk_last;
    logic [COOR_WIDTH:0]       x_sum;
    logic [COOR_WIDTH:0]       y_sum;
    logic                      clipped;

    assign frame_start = bus.rst_screen_33m && !rs_q;

    // Walker control and screen-position/clip decode for the current pixel.
    always_comb begin
        cur_desc     = desc_q[idx_q[SEL_W-1:0]];
        cur_drawable = (idx_q < IDX_W'(NUM_REQ)) && cur_desc.en &&
                       (cur_desc.w != '0) && (cur_desc.h != '0);
        walk_start   = (state_q == ST_SELECT) && cur_drawable;
        walk_w       = COOR_WIDTH'(cur_desc.w);
        walk_h       = COOR_WIDTH'(cur_desc.h);
`ifdef FB_DRAW_CLEAR_EN
        if (state_q == ST_WAIT_BLANK) begin
            walk_start = 1'b1;
            walk_w     = COOR_WIDTH'(FRAME_W);
            walk_h     = COOR_WIDTH'(FRAME_H);
        end
`endif
        walk_step = (state_q == ST_DRAW) || (state_q == ST_CLEAR);
        x_sum     = {1'b0, cur_desc.x} + {1'b0, walk_u};
        y_sum     = {1'b0, cur_desc.y} + {1'b0, walk_v};
        clipped   = x_sum[COOR_WIDTH] || y_sum[COOR_WIDTH] ||
                    (x_sum >= (COOR_WIDTH+1)'(FRAME_W)) ||
                    (y_sum >= (COOR_WIDTH+1)'(FRAME_H));
    end

    fb_rect_walker #(
        .WIDTH (COOR_WIDTH)
    ) u_walker (
        .clk_i   (clk_33m),
        .rst_n_i (rst_n),
        .start_i (walk_start),
        .step_i  (walk_step),
        .w_i     (walk_w),
        .h_i     (walk_h),
        .u_o     (walk_u),
        .v_o     (walk_v),
        .last_o  (walk_last)
    );

    // Scheduler FSM plus the issue/write pipeline; a frame start overrides
    // everything and flushes whatever is still in flight.
    always_ff @(posedge clk_33m) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rs_q         <= 1'b0;
            idx_q        <= '0;
            drain_q      <= '0;
            rom_addr_q   <= '0;
            addr_cnt_q   <= '0;
            spr_done_q   <= '0;
            frame_busy_q <= 1'b0;
            overrun_q    <= 1'b0;
            wx_q         <= '0;
            wy_q         <= '0;
            wpal_q       <= TRANSPARENT_PALETTE;
            for (int i = 0; i < NUM_REQ; i++) desc_q[i] <= '0;
            for (int i = 0; i <= ROM_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            rs_q       <= bus.rst_screen_33m;
            spr_done_q <= '0;
            for (int i = 1; i <= ROM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            pipe_q[0] <= '0;
            wx_q      <= pipe_q[ROM_LATENCY].x;
            wy_q      <= pipe_q[ROM_LATENCY].y;
            if (pipe_q[ROM_LATENCY].rd)
                wpal_q <= bus.rom_q;
            else if (pipe_q[ROM_LATENCY].clr)
                wpal_q <= CLEAR_PALETTE;
            else
                wpal_q <= TRANSPARENT_PALETTE;

            if (frame_start) begin
                if (state_q != ST_IDLE) begin
                    overrun_q <= 1'b1;
                    wpal_q    <= TRANSPARENT_PALETTE;
                    for (int i = 0; i <= ROM_LATENCY; i++) pipe_q[i] <= '0;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    desc_q[i] <= '{en:   bus.spr_en[i],
                                   x:    bus.spr_x[i],
                                   y:    bus.spr_y[i],
                                   w:    bus.spr_w[i],
                                   h:    bus.spr_h[i],
                                   base: bus.spr_base[i]};
                end
                idx_q        <= '0;
                frame_busy_q <= 1'b1;
                state_q      <= ST_WAIT_BLANK;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_WAIT_BLANK: begin
                        idx_q <= '0;
                        if (!bus.rst_screen_33m) begin
`ifdef FB_DRAW_CLEAR_EN
                            state_q <= ST_CLEAR;
`else
                            state_q <= ST_SELECT;
`endif
                        end
                    end
                    ST_CLEAR: begin
                        pipe_q[0] <= '{rd: 1'b0, clr: 1'b1, x: walk_u, y: walk_v};
                        if (walk_last) state_q <= ST_SELECT;
                    end
                    ST_SELECT: begin
                        if (idx_q == IDX_W'(NUM_REQ)) begin
                            drain_q <= '0;
                            state_q <= ST_DRAIN;
                        end else if (cur_drawable) begin
                            addr_cnt_q <= cur_desc.base;
                            state_q    <= ST_DRAW;
                        end else begin
                            spr_done_q[idx_q[SEL_W-1:0]] <= 1'b1;
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                    ST_DRAW: begin
                        // Row-major ROM layout makes the address a running pixel count.
                        pipe_q[0] <= '{rd: !clipped, clr: 1'b0,
                                       x: x_sum[COOR_WIDTH-1:0], y: y_sum[COOR_WIDTH-1:0]};
                        if (!clipped) rom_addr_q <= addr_cnt_q;
                        addr_cnt_q <= addr_cnt_q + ROM_ADDR_WIDTH'(1);
                        if (walk_last) begin
                            spr_done_q[idx_q[SEL_W-1:0]] <= 1'b1;
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_SELECT;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_q == DRN_W'(ROM_LATENCY)) begin
                            frame_busy_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            drain_q <= drain_q + DRN_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.rom_rd        = pipe_q[0].rd;
    assign bus.rom_addr      = rom_addr_q;
    assign bus.write_x       = wx_q;
    assign bus.write_y       = wy_q;
    assign bus.write_palette = wpal_q;
    assign bus.spr_done      = spr_done_q;
    assign bus.frame_busy    = frame_busy_q;
    assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_fb_draw_scheduler.sv
// Self-checking bench for fb_draw_scheduler (default build, clear disabled):
// directed frames, randomized frames and an overrun, against a pixel-list model.
module tb_fb_draw_scheduler;
    import fb_sched_pkg::*;

    localparam int LAT = 2;

    logic clk_33m = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_33m = ~clk_33m;

    fb_draw_scheduler_if bus();

    fb_draw_scheduler #(
        .ROM_LATENCY (LAT),
        .FRAME_W     (1280),
        .FRAME_H     (300)
    ) dut (
        .clk_33m (clk_33m),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Sprite ROM stand-in with a fixed read latency of LAT cycles.
    int romMode = 0;
    logic rd1 = 1'b0, rd2 = 1'b0;
    logic [13:0] a1 = '0, a2 = '0;

    function automatic logic [2:0] romValue(input logic [13:0] a, input int mode);
        if (mode == 0) return a[2:0] | 3'd1;
        return a[2:0] ^ a[5:3];
    endfunction

    always @(posedge clk_33m) begin
        rd1 <= bus.rom_rd;
        a1  <= bus.rom_addr;
        rd2 <= rd1;
        a2  <= a1;
    end
    assign bus.rom_q = rd2 ? romValue(a2, romMode) : 3'd0;

    int cyc = 0;
    always @(posedge clk_33m) cyc <= cyc + 1;

    // Observation queues filled away from the active edge.
    bit          collect = 1'b0;
    logic [26:0] obsW[$];
    int          obsWCyc[$];
    int          obsAddr[$];
    int          obsRdCyc[$];
    logic [3:0]  obsDone = '0;

    always @(negedge clk_33m) begin
        if (collect) begin
            if (bus.write_palette != 3'd0) begin
                obsW.push_back({bus.write_x, bus.write_y, bus.write_palette});
                obsWCyc.push_back(cyc);
            end
            if (bus.rom_rd) begin
                obsAddr.push_back(int'(bus.rom_addr));
                obsRdCyc.push_back(cyc);
            end
            obsDone = obsDone | bus.spr_done;
        end
    end

    int dEn[NUM_REQ], dX[NUM_REQ], dY[NUM_REQ], dW[NUM_REQ], dH[NUM_REQ], dBase[NUM_REQ];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearObs();
        obsW.delete();
        obsWCyc.delete();
        obsAddr.delete();
        obsRdCyc.delete();
        obsDone = '0;
    endtask

    task automatic driveDescriptors();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.spr_en[i]   = (dEn[i] != 0);
            bus.spr_x[i]    = 12'(dX[i]);
            bus.spr_y[i]    = 12'(dY[i]);
            bus.spr_w[i]    = 8'(dW[i]);
            bus.spr_h[i]    = 8'(dH[i]);
            bus.spr_base[i] = 14'(dBase[i]);
        end
    endtask

    task automatic driveJunk();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.spr_en[i]   = 1'($urandom);
            bus.spr_x[i]    = 12'($urandom);
            bus.spr_y[i]    = 12'($urandom);
            bus.spr_w[i]    = 8'($urandom);
            bus.spr_h[i]    = 8'($urandom);
            bus.spr_base[i] = 14'($urandom);
        end
    endtask

    task automatic waitIdle(input string tag);
        int budget = 0;
        while (bus.frame_busy && budget < 20000) begin
            @(negedge clk_33m);
            budget++;
        end
        checkOutput(tag, budget < 20000, 1);
        repeat (3) @(negedge clk_33m);
    endtask

    // One complete frame: latch descriptors on the rising edge, then scramble inputs.
    task automatic applyStimulus();
        clearObs();
        collect = 1'b1;
        @(posedge clk_33m); #1;
        driveDescriptors();
        bus.rst_screen_33m = 1'b1;
        @(negedge clk_33m);
        checkOutput("busyPre", bus.frame_busy, 0);
        @(negedge clk_33m);
        checkOutput("busyRise", bus.frame_busy, 1);
        @(posedge clk_33m); #1;
        driveJunk();
        repeat (3) @(posedge clk_33m);
        #1 bus.rst_screen_33m = 1'b0;
        waitIdle("frameDone");
        collect = 1'b0;
    endtask

    task automatic checkFrame(input string tag, input bit timing);
        logic [26:0] expW[$];
        int expAddr[$];
        int x, y, a, n;
        logic [2:0] p;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (dEn[i] != 0 && dW[i] > 0 && dH[i] > 0) begin
                for (int v = 0; v < dH[i]; v++) begin
                    for (int u = 0; u < dW[i]; u++) begin
                        x = dX[i] + u;
                        y = dY[i] + v;
                        if (x < 1280 && y < 300) begin
                            a = (dBase[i] + v * dW[i] + u) % 16384;
                            expAddr.push_back(a);
                            p = romValue(14'(a), romMode);
                            if (p != 3'd0) expW.push_back({12'(x), 12'(y), p});
                        end
                    end
                end
            end
        end
        checkOutput({tag, ".nWrites"}, obsW.size(), expW.size());
        n = (obsW.size() < expW.size()) ? obsW.size() : expW.size();
        for (int k = 0; k < n; k++) checkOutput({tag, ".write"}, obsW[k], expW[k]);
        checkOutput({tag, ".nReads"}, obsAddr.size(), expAddr.size());
        n = (obsAddr.size() < expAddr.size()) ? obsAddr.size() : expAddr.size();
        for (int k = 0; k < n; k++) checkOutput({tag, ".addr"}, obsAddr[k], expAddr[k]);
        checkOutput({tag, ".done"}, obsDone, 4'hF);
        if (timing) begin
            n = (obsW.size() < obsRdCyc.size()) ? obsW.size() : obsRdCyc.size();
            for (int k = 0; k < n; k++)
                checkOutput({tag, ".latency"}, obsWCyc[k] - obsRdCyc[k], LAT + 1);
            if (obsRdCyc.size() > 0)
                checkOutput({tag, ".noBubble"}, obsRdCyc[obsRdCyc.size()-1] - obsRdCyc[0],
                            obsRdCyc.size() - 1);
        end
    endtask

    task automatic setSprite(input int i, input int en, input int x, input int y,
                             input int w, input int h, input int base);
        dEn[i] = en; dX[i] = x; dY[i] = y; dW[i] = w; dH[i] = h; dBase[i] = base;
    endtask

    task automatic disableAll();
        for (int i = 0; i < NUM_REQ; i++) setSprite(i, 0, 0, 0, 0, 0, 0);
    endtask

    logic [2:0] last55;
    int budget;

    initial begin
        bus.rst_screen_33m = 1'b0;
        disableAll();
        driveDescriptors();

        repeat (3) @(posedge clk_33m);
        @(negedge clk_33m);
        checkOutput("rst.write_x", bus.write_x, 0);
        checkOutput("rst.write_y", bus.write_y, 0);
        checkOutput("rst.palette", bus.write_palette, 0);
        checkOutput("rst.rom_rd", bus.rom_rd, 0);
        checkOutput("rst.rom_addr", bus.rom_addr, 0);
        checkOutput("rst.spr_done", bus.spr_done, 0);
        checkOutput("rst.busy", bus.frame_busy, 0);
        checkOutput("rst.overrun", bus.overrun, 0);
        @(posedge clk_33m); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk_33m);

        $display("[TB] single sprite");
        romMode = 0;
        disableAll();
        setSprite(0, 1, 10, 20, 3, 2, 100);
        applyStimulus();
        checkFrame("single", 1'b1);

        $display("[TB] right-edge clip");
        disableAll();
        setSprite(1, 1, 1278, 50, 4, 1, 200);
        applyStimulus();
        checkFrame("clip", 1'b1);

        $display("[TB] painter order");
        disableAll();
        setSprite(0, 1, 5, 5, 2, 2, 0);
        setSprite(1, 0, 5, 5, 2, 2, 40);
        setSprite(2, 1, 5, 5, 2, 2, 6);
        applyStimulus();
        checkFrame("order", 1'b0);
        last55 = 3'd0;
        foreach (obsW[k])
            if (obsW[k][26:15] == 12'd5 && obsW[k][14:3] == 12'd5) last55 = obsW[k][2:0];
        checkOutput("order.top", last55, 3'd7);

        $display("[TB] all zero width");
        for (int i = 0; i < NUM_REQ; i++) setSprite(i, 1, 10 * i, 10, 0, 3, 0);
        applyStimulus();
        checkFrame("zeroW", 1'b0);

        $display("[TB] random frames");
        romMode = 1;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                setSprite(i, int'($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1270, 1279))
                                                      : int'($urandom_range(0, 1300)),
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(295, 299))
                                                      : int'($urandom_range(0, 310)),
                          int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(16370, 16383))
                                                      : int'($urandom_range(0, 16383)));
            end
            applyStimulus();
            checkFrame("random", 1'b0);
        end

        $display("[TB] overrun mid-draw");
        romMode = 0;
        disableAll();
        setSprite(0, 1, 0, 0, 50, 10, 0);
        clearObs();
        collect = 1'b1;
        @(posedge clk_33m); #1;
        driveDescriptors();
        bus.rst_screen_33m = 1'b1;
        repeat (4) @(posedge clk_33m);
        #1 bus.rst_screen_33m = 1'b0;
        budget = 0;
        while (obsRdCyc.size() < 10 && budget < 200) begin
            @(negedge clk_33m);
            budget++;
        end
        checkOutput("ovr.drawing", budget < 200, 1);
        @(posedge clk_33m); #1;
        disableAll();
        setSprite(1, 1, 100, 100, 3, 3, 40);
        driveDescriptors();
        bus.rst_screen_33m = 1'b1;
        @(negedge clk_33m);
        checkOutput("ovr.before", bus.overrun, 0);
        @(negedge clk_33m);
        checkOutput("ovr.set", bus.overrun, 1);
        checkOutput("ovr.flush", bus.write_palette, 0);
        checkOutput("ovr.rdStop", bus.rom_rd, 0);
        clearObs();
        repeat (3) @(posedge clk_33m);
        #1 bus.rst_screen_33m = 1'b0;
        waitIdle("ovr.frameDone");
        collect = 1'b0;
        checkFrame("ovrNext", 1'b0);
        checkOutput("ovr.sticky", bus.overrun, 1);

        @(posedge clk_33m); #1 rst_n = 1'b0;
        @(posedge clk_33m);
        @(negedge clk_33m);
        checkOutput("ovr.rstClear", bus.overrun, 0);
        checkOutput("ovr.rstBusy", bus.frame_busy, 0);
        @(posedge clk_33m); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk_33m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
